// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - sram-like memory bus between the port arbiter (master) and the memory (slave)
interface sram_port_arbiter_if;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - inst/data port arbiter onto one sram-like bus; ARB_FAIR_EN adds inst starvation relief
module sram_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [31:0]         inst_addr,
    output logic [31:0]         inst_rdata,
    output logic                inst_done,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [3:0]          data_wstrb,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic [31:0]         data_rdata,
    output logic                data_done,
    sram_port_arbiter_if.master bus,
    output logic                stall
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        gnt_q;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        any_req;
    logic        pick_data;

    assign any_req = inst_req | data_req;

    // Elaboration-only guard: the block exists only for an unusable counter configuration.
    if (STARVE_MAX < 1 || STARVE_MAX >= (1 << CNT_W)) begin : g_bad_starve_cfg
    end

`ifdef ARB_FAIR_EN
    logic [CNT_W-1:0] starve_cnt_q;
    logic             starved;

    assign starved   = inst_req && (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign pick_data = data_req && !starved;

    // Saturation is implicit: at STARVE_MAX a waiting inst always wins and clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            if (!pick_data)
                starve_cnt_q <= '0;
            else if (inst_req)
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end
`else
    assign pick_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        inst_done = 1'b0;
        data_done = 1'b0;
        case (state_q)
            IDLE: if (any_req) state_d = ADDR;
            ADDR: if (bus.bus_addr_ok) state_d = DATA;
            DATA: if (bus.bus_data_ok) state_d = RESP;
            RESP: begin
                state_d   = IDLE;
                inst_done = !gnt_q;
                data_done = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q        <= 1'b0;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                gnt_q   <= pick_data;
                wr_q    <= pick_data & data_wr;
                wstrb_q <= pick_data ? data_wstrb : 4'b0000;
                addr_q  <= pick_data ? data_addr : inst_addr;
                wdata_q <= pick_data ? data_wdata : 32'h0;
            end
            // Write responses carry no payload, so data_rdata keeps the last read word.
            if (state_q == DATA && bus.bus_data_ok) begin
                if (!gnt_q)
                    inst_rdata_q <= bus.bus_rdata;
                else if (!wr_q)
                    data_rdata_q <= bus.bus_rdata;
            end
        end
    end

    assign bus.bus_req   = (state_q == ADDR);
    assign bus.bus_wr    = wr_q;
    assign bus.bus_wstrb = wstrb_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign stall      = (inst_req & ~inst_done) | (data_req & ~data_done);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - bench for sram_port_arbiter; honours ARB_FAIR_EN when defined
module tb_sram_port_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        stall;

    sram_port_arbiter_if bus_if ();

    sram_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_done  (inst_done),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_wstrb (data_wstrb),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_done  (data_done),
        .bus        (bus_if),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Reference transaction: who owns the bus and how far the handshake has progressed.
    typedef struct packed {
        logic        valid;
        logic        acc;
        logic        ret;
        logic        port;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          port;
        bit          wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        int          exp_done;
        logic [31:0] exp_rdata;
    } vec_t;

    txn_t        m;
    logic [31:0] m_inst_rdata, m_data_rdata;
    int          m_cnt;
    bit          chk_en;
    bit          saw_idone, saw_ddone, exp_idone, exp_ddone;
    logic [31:0] saw_bus_addr;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [6];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic cycle_check();
        bit gi;
        bit e_breq;
        #3;
        e_breq       = m.valid && !m.acc;
        exp_idone    = m.valid && m.ret && !m.port;
        exp_ddone    = m.valid && m.ret && m.port;
        saw_idone    = inst_done;
        saw_ddone    = data_done;
        saw_bus_addr = bus_if.bus_addr;
        if (chk_en) begin
            check1("bus_req", 32'(bus_if.bus_req), 32'(e_breq));
            if (e_breq) begin
                check1("bus_addr", bus_if.bus_addr, m.addr);
                check1("bus_wr", 32'(bus_if.bus_wr), 32'(m.wr));
                if (m.port) begin
                    check1("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(m.wstrb));
                    check1("bus_wdata", bus_if.bus_wdata, m.wdata);
                end
            end
            check1("inst_done", 32'(inst_done), 32'(exp_idone));
            check1("data_done", 32'(data_done), 32'(exp_ddone));
            check1("inst_rdata", inst_rdata, m_inst_rdata);
            check1("data_rdata", data_rdata, m_data_rdata);
            check1("stall", 32'(stall),
                   32'((inst_req & ~exp_idone) | (data_req & ~exp_ddone)));
        end
        if (reset) begin
            m            = '0;
            m_inst_rdata = '0;
            m_data_rdata = '0;
            m_cnt        = 0;
        end else if (m.valid) begin
            if (m.ret) begin
                m.valid = 1'b0;
            end else if (m.acc) begin
                if (bus_if.bus_data_ok) begin
                    m.ret = 1'b1;
                    if (!m.port) m_inst_rdata = bus_if.bus_rdata;
                    else if (!m.wr) m_data_rdata = bus_if.bus_rdata;
                end
            end else if (bus_if.bus_addr_ok) begin
                m.acc = 1'b1;
            end
        end else if (inst_req || data_req) begin
            gi = inst_req && !data_req;
`ifdef ARB_FAIR_EN
            if (inst_req && m_cnt == STARVE_MAX) gi = 1'b1;
            if (gi) m_cnt = 0;
            else if (inst_req && m_cnt < STARVE_MAX) m_cnt++;
`endif
            m       = '0;
            m.valid = 1'b1;
            m.port  = !gi;
            m.wr    = gi ? 1'b0 : data_wr;
            m.wstrb = data_wstrb;
            m.addr  = gi ? inst_addr : data_addr;
            m.wdata = data_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_at, i_at, n, ndone;
        int got [6];
        int exp_order [6];
        logic [31:0] a_addr;

        vecs[0] = '{port:0, wr:0, wstrb:4'h0, addr:32'hbfc00000, wdata:32'h0, rdata:32'h24080001,
                    aw:0, dw:0, exp_done:3, exp_rdata:32'h24080001};
        vecs[1] = '{port:1, wr:0, wstrb:4'hf, addr:32'h80000020, wdata:32'h0, rdata:32'h11223344,
                    aw:1, dw:2, exp_done:6, exp_rdata:32'h11223344};
        vecs[2] = '{port:1, wr:1, wstrb:4'b0011, addr:32'h80000010, wdata:32'hdeadbeef, rdata:32'hffffffff,
                    aw:0, dw:0, exp_done:3, exp_rdata:32'h11223344};
        vecs[3] = '{port:0, wr:0, wstrb:4'h0, addr:32'h00000004, wdata:32'h0, rdata:32'hcafef00d,
                    aw:5, dw:0, exp_done:8, exp_rdata:32'hcafef00d};
        vecs[4] = '{port:1, wr:0, wstrb:4'hf, addr:32'h0000fffc, wdata:32'h0, rdata:32'h00000000,
                    aw:0, dw:3, exp_done:6, exp_rdata:32'h00000000};
        vecs[5] = '{port:0, wr:0, wstrb:4'h0, addr:32'hfffffffc, wdata:32'h0, rdata:32'ha5a5a5a5,
                    aw:2, dw:1, exp_done:6, exp_rdata:32'ha5a5a5a5};

        chk_en = 1'b0;
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = '0;
        @(posedge clk);
        #1;
        cycle_check();
        cycle_check();
        chk_en = 1'b1;
        cycle_check();
        reset = 1'b0;
        cycle_check();

        // Single transactions with scripted bus wait states.
        for (int i = 0; i < 6; i++) begin
            d_at = -1;
            for (int c = 0; c < 24 && d_at < 0; c++) begin
                if (c == 0) begin
                    if (vecs[i].port) begin
                        data_req = 1'b1; data_wr = vecs[i].wr; data_wstrb = vecs[i].wstrb;
                        data_addr = vecs[i].addr; data_wdata = vecs[i].wdata;
                    end else begin
                        inst_req = 1'b1; inst_addr = vecs[i].addr;
                    end
                end else if (vecs[i].port && c >= 2) begin
                    data_addr = $urandom; data_wdata = $urandom;
                end
                bus_if.bus_addr_ok = (c == 1 + vecs[i].aw);
                bus_if.bus_data_ok = (c == 2 + vecs[i].aw + vecs[i].dw);
                bus_if.bus_rdata   = bus_if.bus_data_ok ? vecs[i].rdata : $urandom;
                cycle_check();
                if (vecs[i].port ? saw_ddone : saw_idone) d_at = c;
            end
            check1($sformatf("vec%0d done cycle", i), d_at, vecs[i].exp_done);
            check1($sformatf("vec%0d rdata", i), vecs[i].port ? data_rdata : inst_rdata, vecs[i].exp_rdata);
            inst_req = 1'b0; data_req = 1'b0;
            bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
            cycle_check();
        end

        // Simultaneous requests, zero-wait bus: data first, inst four cycles later.
        d_at = -1; i_at = -1; a_addr = '0;
        inst_req = 1'b1; inst_addr = 32'h00400000;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000100;
        bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h13572468;
        for (int c = 0; c < 16; c++) begin
            if (d_at >= 0) data_req = 1'b0;
            if (i_at >= 0) inst_req = 1'b0;
            cycle_check();
            if (c == 1) a_addr = saw_bus_addr;
            if (saw_ddone && d_at < 0) d_at = c;
            if (saw_idone && i_at < 0) i_at = c;
        end
        check1("both first grant addr", a_addr, 32'h80000100);
        check1("both data_done cycle", d_at, 3);
        check1("both inst_done cycle", i_at, 7);

        // Reset while waiting in DATA; the late data_ok must be ignored.
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000200;
        cycle_check();
        bus_if.bus_addr_ok = 1'b1;
        cycle_check();
        bus_if.bus_addr_ok = 1'b0;
        cycle_check();
        reset = 1'b1; data_req = 1'b0;
        cycle_check();
        reset = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h12345678;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            cycle_check();
            ndone += int'(saw_ddone);
            bus_if.bus_data_ok = 1'b0;
        end
        check1("reset no done", ndone, 0);
        check1("reset data_rdata", data_rdata, 32'h0);
        check1("reset bus_req", 32'(bus_if.bus_req), 32'h0);

        // Both ports held continuously: grant order depends on the fairness build.
`ifdef ARB_FAIR_EN
        exp_order = '{1, 1, 1, 1, 0, 1};
`else
        exp_order = '{1, 1, 1, 1, 1, 1};
`endif
        got = '{-1, -1, -1, -1, -1, -1};
        n = 0;
        inst_req = 1'b1; inst_addr = 32'h00001000;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00002000;
        bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1;
        for (int c = 0; c < 80 && n < 6; c++) begin
            bus_if.bus_rdata = $urandom;
            cycle_check();
            if (saw_ddone) begin got[n] = 1; n++; end
            else if (saw_idone) begin got[n] = 0; n++; end
        end
        for (int k = 0; k < 6; k++)
            check1($sformatf("held grant %0d port", k), got[k], exp_order[k]);
        inst_req = 1'b0; data_req = 1'b0;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
        cycle_check();
        cycle_check();

        // Random requesters, bus and occasional reset against the reference model.
        for (int c = 0; c < 2500; c++) begin
            if (exp_idone) inst_req = 1'b0;
            if (exp_ddone) data_req = 1'b0;
            if (!inst_req && $urandom_range(2) == 0) begin
                inst_req = 1'b1; inst_addr = $urandom;
            end
            if (!data_req && $urandom_range(2) == 0) begin
                data_req = 1'b1; data_wr = 1'($urandom_range(1));
                data_wstrb = 4'($urandom_range(15));
                data_addr = $urandom; data_wdata = $urandom;
            end
            bus_if.bus_addr_ok = 1'($urandom_range(1));
            bus_if.bus_data_ok = ($urandom_range(2) == 0);
            bus_if.bus_rdata   = $urandom;
            reset = ($urandom_range(149) == 0);
            if (reset) begin
                inst_req = 1'b0; data_req = 1'b0;
            end
            cycle_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
